rx_flag_fifo: RTL and testbench
===============================

# rx_flag_fifo

Receive-side buffer between the character receiver and the host/protocol logic. Watches the receiver's held status flags (data ready, frame error, overrun), captures each completed character with its error tags into a small FIFO, and acknowledges the receiver. It then presents entries to the consumer over a valid/ready handshake. This decouples host read latency from the one-character holding register in the receiver.

## Interface
Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries (min 1)

Ports:
- clk  in  1  system clock, all logic rising-edge
- nReset  in  1  asynchronous, active-low reset
- rxData  in  8  receiver data byte, valid while rxDataReady or rxFrameError is high
- rxDataReady  in  1  receiver flag, held until acknowledged
- rxFrameError  in  1  receiver flag (parity/stop error), held until acknowledged
- rxOverrun  in  1  receiver flag, held until acknowledged
- rxAck  out  1  one-cycle pulse clearing receiver flags
- flush  in  1  synchronous FIFO clear
- outData  out  8  head entry data
- outFrameError  out  1  head entry frame-error tag
- outOverrun  out  1  head entry overrun tag
- outValid  out  1  head entry present
- outReady  in  1  consumer accepts head when outValid high
- level  out  DEPTH_LOG2+1  current entry count
- full  out  1  level == depth

## Operation
- Entry = {overrun, frameError, data[7:0]}, 10 bits.
- Capture FSM states: IDLE, ACK, WAIT_CLEAR.
  - IDLE: when (rxDataReady | rxFrameError) and push allowed -> write entry {rxOverrun, rxFrameError, rxData}, go to ACK.
  - ACK: rxAck=1 for exactly this cycle -> WAIT_CLEAR.
  - WAIT_CLEAR: stay while rxDataReady | rxFrameError is high; otherwise -> IDLE. Minimum one cycle; this prevents double capture of a stale flag.
- Push allowed = !full, or full with a pop in the same cycle. If full, no capture and no ack occur, and the receiver keeps its byte. A later receiver overrun is then reported through rxOverrun on the eventual capture.
- Pop: outValid & outReady removes the head.
- Simultaneous push and pop: both take effect, and level is unchanged.
- flush has priority over push and pop. level becomes 0 and outValid becomes 0 next cycle. The FSM is unaffected: a capture in the flush cycle is discarded, but its ack is still issued.
- rxOverrun alone (without ready/error) does not trigger a capture.
- Pointers wrap modulo depth. level is computed from (DEPTH_LOG2+1)-bit pointers, and full is taken from the pointer MSB difference.

## Timing
- Reset values: rxAck=0, outValid=0, outData=0, outFrameError=0, outOverrun=0, level=0, full=0, FSM=IDLE.
- Reset mid-operation: all state clears immediately, and pending entries are lost. The receiver flags are not acked and will be recaptured after reset.
- Capture latency: flag high in cycle N (IDLE) -> entry written at the N edge, rxAck high in N+1, level updated in N+1.
- Empty-to-valid latency: outValid high in the cycle after the write edge. There is no fall-through within the same cycle.
- Output regs: outData/tags always show the head entry. They are registered, and their values are undefined when outValid=0 except after reset.
- Back-to-back characters: throughput is one capture per 3 cycles minimum. This is far above any character rate.

## Structure
- Shared header/package: FSM state encodings (IDLE, ACK, WAIT_CLEAR) and entry field widths/offsets (ENTRY_W=10, FE_BIT=8, OVR_BIT=9).
- Sub-module `sync_fifo`: parameterised width/depth RAM with pointers, level, full, empty, and flush. Reusable on the transmit side. The capture FSM lives in rx_flag_fifo.

## Test plan
- Single byte: rxData=0x3B, rxDataReady held until rxAck -> one rxAck pulse, level=1, outValid=1, outData=0x3B, tags 0. Pop with outReady -> level=0.
- Frame error: rxData=0xA5, rxFrameError=1, rxOverrun=1 -> entry 0xA5, outFrameError=1, outOverrun=1. Exactly one ack.
- Fill: DEPTH_LOG2=3, outReady=0, send 9 bytes 0x00..0x08 -> level=8, full=1, 9th byte un-acked. Pop one -> 9th captured in the same cycle, level stays 8. Drain order 0x01..0x08.
- Stuck flag: rxDataReady held 5 cycles after rxAck -> FSM remains in WAIT_CLEAR, with no second capture and level=1.
- Flush during capture: flush asserted in the write cycle with level=3 -> level=0, outValid=0, and rxAck still pulsed once.
- Async reset: nReset low with level=5 during ACK -> all outputs at reset values without a clock edge. After release, the held rxDataReady is recaptured.

Source files
------------

// File: rtl/rx_flag_fifo_pkg.sv
// rx_flag_fifo shared types: capture FSM states and entry layout.
// Entry is {overrun, frameError, data[7:0]}.
package rx_flag_fifo_pkg;

  localparam int DATA_W  = 8;
  localparam int ENTRY_W = 10;
  localparam int FE_BIT  = 8;
  localparam int OVR_BIT = 9;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACK        = 2'd1,
    WAIT_CLEAR = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic              ovr;
    logic              fe;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  function automatic rx_entry_t pack_entry(
    input logic              ovr,
    input logic              fe,
    input logic [DATA_W-1:0] data
  );
    rx_entry_t e;
    e.ovr  = ovr;
    e.fe   = fe;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/rx_flag_fifo_sync_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers and a flush.
// Head word is read straight from the storage registers.
module sync_fifo #(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                flush,
  input  logic                push,
  input  logic                pop,
  input  logic [W-1:0]        wdata,
  output logic [W-1:0]        rdata,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int A     = DEPTH_LOG2;

  logic [W-1:0] mem_q [DEPTH];
  logic [A:0]   wr_ptr_q, wr_ptr_d;
  logic [A:0]   rd_ptr_q, rd_ptr_d;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[A] != rd_ptr_q[A]) &&
                   (wr_ptr_q[A-1:0] == rd_ptr_q[A-1:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q[A-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer next-state; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush) begin
      mem_q[wr_ptr_q[A-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/rx_flag_fifo.sv
// Receive-side capture FSM plus entry FIFO.
// Captures held receiver flags, acks once, waits for them to drop.
module rx_flag_fifo
  import rx_flag_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [7:0]          rxData,
  input  logic                rxDataReady,
  input  logic                rxFrameError,
  input  logic                rxOverrun,
  output logic                rxAck,
  input  logic                flush,
  output logic [7:0]          outData,
  output logic                outFrameError,
  output logic                outOverrun,
  output logic                outValid,
  input  logic                outReady,
  output logic [DEPTH_LOG2:0] level,
  output logic                full
);

  cap_state_e state_q, state_d;
  rx_entry_t  wr_entry;
  rx_entry_t  head;
  logic       capture;
  logic       pop;
  logic       push_ok;
  logic       rx_flag;
  logic       fifo_empty;
  logic       fifo_full;

  assign rx_flag  = rxDataReady | rxFrameError;
  assign outValid = ~fifo_empty;
  assign pop      = outValid & outReady;
  assign push_ok  = ~fifo_full | pop;
  assign wr_entry = pack_entry(rxOverrun, rxFrameError, rxData);

  // Capture FSM next-state and ack decode.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    rxAck   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_flag && push_ok) begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        rxAck   = 1'b1;
        state_d = WAIT_CLEAR;
      end
      WAIT_CLEAR: begin
        if (!rx_flag) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture FSM state register.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  sync_fifo #(
    .W          (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .nReset (nReset),
    .flush  (flush),
    .push   (capture),
    .pop    (pop),
    .wdata  (wr_entry),
    .rdata  (head),
    .level  (level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign full          = fifo_full;
  assign outData       = head.data;
  assign outFrameError = head.fe;
  assign outOverrun    = head.ovr;

endmodule

// File: tb/tb_rx_flag_fifo.sv
// Directed bench for rx_flag_fifo (DEPTH_LOG2=3).
// Receiver flags are cleared on the edge that sees rxAck.
module tb_rx_flag_fifo;

  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] rxData;
  logic       rxDataReady;
  logic       rxFrameError;
  logic       rxOverrun;
  logic       rxAck;
  logic       flush;
  logic [7:0] outData;
  logic       outFrameError;
  logic       outOverrun;
  logic       outValid;
  logic       outReady;
  logic [3:0] level;
  logic       full;

  int n_cmp = 0;
  int n_err = 0;
  int acks  = 0;
  int acks0;
  bit auto_clear = 1'b1;

  always #5 clk = ~clk;

  rx_flag_fifo #(.DEPTH_LOG2(3)) dut (
    .clk           (clk),
    .nReset        (nReset),
    .rxData        (rxData),
    .rxDataReady   (rxDataReady),
    .rxFrameError  (rxFrameError),
    .rxOverrun     (rxOverrun),
    .rxAck         (rxAck),
    .flush         (flush),
    .outData       (outData),
    .outFrameError (outFrameError),
    .outOverrun    (outOverrun),
    .outValid      (outValid),
    .outReady      (outReady),
    .level         (level),
    .full          (full)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit ack_seen;
    ack_seen = (rxAck === 1'b1);
    @(posedge clk);
    #1;
    if (ack_seen) begin
      acks++;
      if (auto_clear) begin
        rxDataReady  = 1'b0;
        rxFrameError = 1'b0;
        rxOverrun    = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] d, input logic rdy,
                      input logic fe, input logic ovr);
    int n;
    rxData       = d;
    rxDataReady  = rdy;
    rxFrameError = fe;
    rxOverrun    = ovr;
    n = 0;
    while ((rxDataReady | rxFrameError) && n < 10) begin
      tick();
      n++;
    end
    chk("send_timeout", {31'd0, rxDataReady | rxFrameError}, 0);
    tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, rxAck, 0);
    chk({tag, "_valid"}, outValid, 0);
    chk({tag, "_data"}, outData, 0);
    chk({tag, "_fe"}, outFrameError, 0);
    chk({tag, "_ovr"}, outOverrun, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_full"}, full, 0);
  endtask

  initial begin
    nReset = 1'b0; rxData = 8'h00; rxDataReady = 1'b0;
    rxFrameError = 1'b0; rxOverrun = 1'b0;
    flush = 1'b0; outReady = 1'b0;
    #1;
    chk_reset_vals("rst");
    tick(); tick();
    nReset = 1'b1;
    tick();

    // Single byte
    rxData = 8'h3B; rxDataReady = 1'b1;
    chk("t1_noack_yet", rxAck, 0);
    tick();
    chk("t1_ack", rxAck, 1);
    chk("t1_level", level, 1);
    chk("t1_valid", outValid, 1);
    chk("t1_data", outData, 8'h3B);
    chk("t1_fe", outFrameError, 0);
    chk("t1_ovr", outOverrun, 0);
    tick();
    chk("t1_ack_once", rxAck, 0);
    tick(); tick();
    chk("t1_acks", acks, 1);
    chk("t1_level_hold", level, 1);
    outReady = 1'b1; tick(); outReady = 1'b0;
    chk("t1_pop_level", level, 0);
    chk("t1_pop_valid", outValid, 0);

    // Frame error with overrun
    acks0 = acks;
    send(8'hA5, 1'b0, 1'b1, 1'b1);
    chk("t2_acks", acks - acks0, 1);
    chk("t2_level", level, 1);
    chk("t2_data", outData, 8'hA5);
    chk("t2_fe", outFrameError, 1);
    chk("t2_ovr", outOverrun, 1);
    outReady = 1'b1; tick(); outReady = 1'b0;
    chk("t2_pop", level, 0);

    // Overrun alone does not capture
    rxOverrun = 1'b1;
    tick(); tick(); tick();
    rxOverrun = 1'b0;
    chk("ovr_only_level", level, 0);

    // Fill to full, ninth byte held off
    for (int i = 0; i < 8; i++) send(i[7:0], 1'b1, 1'b0, 1'b0);
    chk("t3_level8", level, 8);
    chk("t3_full", full, 1);
    acks0 = acks;
    rxData = 8'h08; rxDataReady = 1'b1;
    tick(); tick(); tick(); tick();
    chk("t3_no_ack", acks - acks0, 0);
    chk("t3_rxack_low", rxAck, 0);
    chk("t3_level_held", level, 8);
    chk("t3_head0", outData, 8'h00);
    outReady = 1'b1; tick(); outReady = 1'b0;
    chk("t3_swap_level", level, 8);
    chk("t3_swap_full", full, 1);
    chk("t3_swap_ack", rxAck, 1);
    tick(); tick();
    chk("t3_one_ack", acks - acks0, 1);
    outReady = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t3_drain%0d", k), outData, k);
      tick();
    end
    outReady = 1'b0;
    chk("t3_empty", level, 0);
    chk("t3_novalid", outValid, 0);

    // Stuck flag after ack
    acks0 = acks;
    auto_clear = 1'b0;
    rxData = 8'h55; rxDataReady = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("t4_level", level, 1);
    chk("t4_acks", acks - acks0, 1);
    chk("t4_rxack", rxAck, 0);
    rxDataReady = 1'b0;
    auto_clear = 1'b1;
    tick(); tick();
    chk("t4_level_after", level, 1);
    outReady = 1'b1; tick(); outReady = 1'b0;
    chk("t4_pop", level, 0);

    // Flush in the capture cycle
    send(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0, 1'b0);
    chk("t5_level3", level, 3);
    acks0 = acks;
    rxData = 8'h77; rxDataReady = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_level0", level, 0);
    chk("t5_valid0", outValid, 0);
    chk("t5_ack", rxAck, 1);
    tick(); tick();
    chk("t5_acks", acks - acks0, 1);
    chk("t5_still0", level, 0);

    // Async reset during ACK
    for (int i = 0; i < 5; i++) send(8'h40 + i[7:0], 1'b1, 1'b0, 1'b0);
    chk("t6_level5", level, 5);
    rxData = 8'h99; rxDataReady = 1'b1;
    tick();
    chk("t6_in_ack", rxAck, 1);
    #2 nReset = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    tick();
    nReset = 1'b1;
    chk("t6_flag_held", rxDataReady, 1);
    tick();
    chk("t6_recap_ack", rxAck, 1);
    chk("t6_recap_level", level, 1);
    chk("t6_recap_data", outData, 8'h99);
    tick(); tick();
    chk("t6_final_level", level, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
